datapath_seq: RTL and testbench
===============================

# datapath_seq

Sequencer for the register-file / ALU / dual-port RAM datapath. On `start`, it loads two seed words from RAM into registers 0 and 1. It then drives the datapath to compute a recurrence: `reg[i] = reg[i-2] op reg[i-1]` for i = 2..len-1. Each result is written to both the register file and RAM at the same address. It replaces the free-running control block and adds a start/busy/done handshake plus an optional readback self-check.

## Interface
Parameters:
- `ADDR_W`, 6: register-file and RAM address width.
- `DATA_W`, 32: datapath word width. Used only by the verify path.
- `ALU_OP`, 5'd1: ALU opcode driven during compute. Add.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `start`, in, 1: begin a run. Sampled only in IDLE.
- `len`, in, ADDR_W: element count. Latched on an accepted `start`.
- `src`, out, 1: register write-data select. 1 = RAM `doutb`, 0 = ALU result.
- `wer`, out, 1: register-file write enable.
- `wea`, out, 1: RAM port-A write enable.
- `addr1`, out, ADDR_W: register read port 1 address.
- `addr2`, out, ADDR_W: register read port 2 address.
- `addr3`, out, ADDR_W: address shared by register write, RAM `addra` and RAM `addrb`.
- `alu_op`, out, 5: ALU opcode.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `rd_data1`, in, DATA_W: register read port 1 data. Verify only.
- `ram_dout`, in, DATA_W: RAM `doutb`. Verify only.
- `mismatch`, out, 1: sticky compare failure. Verify only.
- `err_addr`, out, ADDR_W: address of the first mismatch. Verify only.

## Operation
- Reset values: all outputs are 0 and the state is IDLE.
- Datapath model used by this block:
  - Register-file reads are combinational; register writes take effect on the `clk` edge when `wer` = 1.
  - RAM port A writes on the edge when `wea` = 1.
  - RAM port B read data appears one cycle after `addrb` is applied.
- State machine:
  - IDLE: outputs 0.
    - `start` = 1 latches `len` into `n`, sets `i` = 0, and moves to LD_A.
    - When VERIFY is compiled in, it also clears `mismatch` and `err_addr`.
  - LD_A: drives `addr3` = `i` with `wer` = 0. Next state is LD_W.
  - LD_W: drives `addr3` = `i`, `src` = 1, `wer` = 1.
    - If `i` = 0: set `i` = 1 and go to LD_A.
    - If `i` = 1: set `i` = 2 and go to EXEC, or to FIN if `n` ≤ 2.
  - EXEC: drives `addr1` = `i`-2, `addr2` = `i`-1, `addr3` = `i`, `src` = 0, `wer` = 1, `wea` = 1, `alu_op` = `ALU_OP`.
    - Then `i`++.
    - Leave for FIN (or VF_A with VERIFY) after the cycle where `i` = `n`-1.
  - VF_A / VF_C (VERIFY only): for `k` = 0..`n`-1.
    - VF_A drives `addr1` = `k`, `addr3` = `k`.
    - VF_C holds both addresses and compares `rd_data1` with `ram_dout`.
  - FIN: `done` = 1, then return to IDLE.
- Boundary conditions:
  - `len` of 0, 1 or 2: both seeds are loaded, no EXEC cycles run, and `wea` never asserts.
  - `len` = 63: the last EXEC uses `addr3` = 62. No address wrap occurs.
  - ALU overflow: results wrap modulo 2^32. This is not flagged.
  - `start` while `busy` = 1: ignored. `len` is not re-latched.
  - Reset asserted mid-run: immediate return to IDLE with all outputs 0. Register-file and RAM contents are not restored.
  - `start` held high through FIN: a new run is accepted in the following IDLE cycle.

## Timing
- Let the cycle after `start` is sampled in IDLE be cycle 1. LD_A/LD_W run in cycles 1–4. EXEC runs in cycles 5..4+max(`n`-2, 0). FIN follows directly.
- Without VERIFY: `done` is high in cycle 5+max(`n`-2, 0).
- With VERIFY: add 2·`n` cycles before FIN.
- All outputs are registered from the state and counters, with no combinational path from `start`.

## Configuration
- `DATAPATH_SEQ_VERIFY_EN`:
  - Defined: VF_A/VF_C states are compiled in.
    - `mismatch` is set in any VF_C cycle where `rd_data1` ≠ `ram_dout`.
    - `err_addr` captures `k` on the first mismatch only.
  - Undefined: EXEC goes directly to FIN. `rd_data1` and `ram_dout` are ignored. `mismatch` and `err_addr` are tied to 0.

## Structure
- Package `datapath_seq_pkg` holds:
  - the state enum (IDLE, LD_A, LD_W, EXEC, VF_A, VF_C, FIN);
  - the `ALU_ADD` = 5'd1 constant;
  - the `ADDR_W` default.
- One sub-module, `seq_counter`: a loadable ADDR_W-bit up-counter with a terminal-compare output. It is used for both `i` and `k`.

## Test plan
- Fibonacci run: RAM[0] = 1, RAM[1] = 1, `len` = 10, `start` pulsed.
  - reg[9] = 55, RAM[9] = 55, RAM[2..8] = 2, 3, 5, 8, 13, 21, 34.
  - `done` is high in cycle 13.
- Short run: `len` = 2.
  - reg0/reg1 are loaded from RAM, `wea` never rises, `done` is high in cycle 5.
- Busy protection: `start` re-pulsed with `len` = 5 during EXEC of a `len` = 10 run.
  - The run completes with `n` = 10 and exactly one `done` pulse.
- Reset mid-run: `rst_n` pulled low during EXEC at `i` = 5.
  - All outputs are 0 asynchronously, the state is IDLE, and a following `start` with `len` = 4 completes normally.
- Verify (macro defined): `len` = 8, with the bench forcing `ram_dout` off by +1 during the VF_C cycle for `k` = 3.
  - `mismatch` = 1, `err_addr` = 3, `done` is high in cycle 27.
- Maximum length: `len` = 63, seeds 1, 1.
  - The last write is at `addr3` = 62 with reg[62] = F(63) mod 2^32.
  - No write occurs to address 63, and `done` is high in cycle 66.

Source files
------------

// File: rtl/datapath_seq_pkg.sv
// rtl/datapath_seq_pkg.sv - shared types and constants for the datapath sequencer
// Holds the sequencer state enum, the ALU add opcode and the default address width.
package datapath_seq_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam logic [4:0] ALU_ADD = 5'd1;

  typedef enum logic [2:0] {
    IDLE,
    LD_A,
    LD_W,
    EXEC,
    VF_A,
    VF_C,
    FIN
  } state_t;

endpackage

// File: rtl/datapath_seq_if.sv
// rtl/datapath_seq_if.sv - control/datapath bundle between sequencer and datapath
// Carries the start/len/busy/done handshake, the register-file/RAM/ALU controls
// (src, wer, wea, addr1..3, alu_op) and the readback self-check signals
// (rd_data1, ram_dout, mismatch, err_addr).
// master: sequencer side. slave: datapath/host side.
interface datapath_seq_if #(
  parameter int ADDR_W = datapath_seq_pkg::DEF_ADDR_W,
  parameter int DATA_W = 32
) ();

  logic              start;
  logic [ADDR_W-1:0] len;
  logic              src;
  logic              wer;
  logic              wea;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;
  logic [4:0]        alu_op;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] ram_dout;
  logic              mismatch;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    input  start, len, rd_data1, ram_dout,
    output src, wer, wea, addr1, addr2, addr3, alu_op, busy, done, mismatch, err_addr
  );

  modport slave (
    output start, len, rd_data1, ram_dout,
    input  src, wer, wea, addr1, addr2, addr3, alu_op, busy, done, mismatch, err_addr
  );

endinterface

// File: rtl/datapath_seq_counter.sv
// rtl/datapath_seq_counter.sv - loadable up-counter with terminal compare
// Ports: clk, rst_n (async active-low), load/load_val (load has priority),
// inc, term (compare value), count, at_term (count == term).
module seq_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - start/busy/done sequencer for the regfile/ALU/RAM datapath
// Loads seeds RAM[0], RAM[1] into reg0/reg1, then computes
// reg[i] = reg[i-2] op reg[i-1] for i = 2..len-1, writing reg and RAM at i.
// Ports: clk, rst_n (async active-low), bus (datapath_seq_if.master).
// Optional readback self-check compiled in with DATAPATH_SEQ_VERIFY_EN.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int         ADDR_W = DEF_ADDR_W,
  parameter int         DATA_W = 32,
  parameter logic [4:0] ALU_OP = ALU_ADD
) (
  input logic            clk,
  input logic            rst_n,
  datapath_seq_if.master bus
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_last;
  logic              n_load, cnt_load, cnt_inc, cnt_at_last;

  logic              src, wer, wea, busy, done;
  logic [ADDR_W-1:0] addr1, addr2, addr3;
  logic [4:0]        alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
    end else if (n_load) begin
      n_q <= bus.len;
    end
  end

  // One counter serves as i during load/compute and as k during readback.
  assign cnt_last = n_q - ADDR_W'(1);

  seq_counter #(.W(ADDR_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (cnt_inc),
    .term     (cnt_last),
    .count    (cnt),
    .at_term  (cnt_at_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    n_load   = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          n_load   = 1'b1;
          cnt_load = 1'b1;
          state_nx = LD_A;
        end
      end
      LD_A: state_nx = LD_W;
      LD_W: begin
        cnt_inc = 1'b1;
        if (cnt == '0) begin
          state_nx = LD_A;
        end else if (n_q > ADDR_W'(2)) begin
          state_nx = EXEC;
        end else begin
          state_nx = FIN;
`ifdef DATAPATH_SEQ_VERIFY_EN
          // Short runs still read back whatever of reg0/reg1 is in range.
          if (n_q != '0) begin
            state_nx = VF_A;
            cnt_load = 1'b1;
          end
`endif
        end
      end
      EXEC: begin
        cnt_inc = 1'b1;
        if (cnt_at_last) begin
          state_nx = FIN;
`ifdef DATAPATH_SEQ_VERIFY_EN
          state_nx = VF_A;
          cnt_load = 1'b1;
`endif
        end
      end
`ifdef DATAPATH_SEQ_VERIFY_EN
      VF_A: state_nx = VF_C;
      VF_C: begin
        if (cnt_at_last) begin
          state_nx = FIN;
        end else begin
          cnt_inc  = 1'b1;
          state_nx = VF_A;
        end
      end
`endif
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode only registered state and counter; start never reaches them.
  always_comb begin
    src    = 1'b0;
    wer    = 1'b0;
    wea    = 1'b0;
    addr1  = '0;
    addr2  = '0;
    addr3  = '0;
    alu_op = '0;
    busy   = (state != IDLE);
    done   = 1'b0;
    case (state)
      LD_A: addr3 = cnt;
      LD_W: begin
        addr3 = cnt;
        src   = 1'b1;
        wer   = 1'b1;
      end
      EXEC: begin
        addr1  = cnt - ADDR_W'(2);
        addr2  = cnt - ADDR_W'(1);
        addr3  = cnt;
        wer    = 1'b1;
        wea    = 1'b1;
        alu_op = ALU_OP;
      end
      VF_A, VF_C: begin
        addr1 = cnt;
        addr3 = cnt;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign bus.src    = src;
  assign bus.wer    = wer;
  assign bus.wea    = wea;
  assign bus.addr1  = addr1;
  assign bus.addr2  = addr2;
  assign bus.addr3  = addr3;
  assign bus.alu_op = alu_op;
  assign bus.busy   = busy;
  assign bus.done   = done;

  logic [DATA_W-1:0] ram_word;
  assign ram_word = bus.ram_dout;

`ifdef DATAPATH_SEQ_VERIFY_EN
  logic              mismatch_q;
  logic [ADDR_W-1:0] err_addr_q;

  // RAM port B data for k is valid in VF_C, one cycle after VF_A applied addrb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      err_addr_q <= '0;
    end else if (state == IDLE && bus.start) begin
      mismatch_q <= 1'b0;
      err_addr_q <= '0;
    end else if (state == VF_C && bus.rd_data1 != ram_word) begin
      mismatch_q <= 1'b1;
      if (!mismatch_q) begin
        err_addr_q <= cnt;
      end
    end
  end

  assign bus.mismatch = mismatch_q;
  assign bus.err_addr = err_addr_q;
`else
  logic unused_verify;
  assign unused_verify = ^{bus.rd_data1, ram_word};
  assign bus.mismatch  = 1'b0;
  assign bus.err_addr  = '0;
`endif

endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - randomized self-checking bench for datapath_seq
module tb_datapath_seq;
  import datapath_seq_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;
`ifdef DATAPATH_SEQ_VERIFY_EN
  localparam int VF = 1;
`else
  localparam int VF = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datapath_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  datapath_seq #(.ADDR_W(AW), .DATA_W(DW), .ALU_OP(ALU_ADD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Datapath environment: register file, RAM with one-cycle port-B latency.
  logic [31:0] regf [64];
  logic [31:0] ram  [64];
  logic [31:0] ram_dout_q = 32'd0;
  bit          w_en, a_en;
  logic [5:0]  w_addr;
  logic [31:0] w_data, a_data, rb_data;
  int          wea_seen;

  int cyc = 0;
  int cur_n = 0;
  bit bump_en = 1'b0;
  int bump_cyc = 0;

  assign bus.rd_data1 = regf[bus.addr1];
  assign bus.ram_dout = ram_dout_q + ((bump_en && cyc == bump_cyc) ? 32'd1 : 32'd0);

  function automatic void chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] sentinel(int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  function automatic int done_cycle(int n);
    return 5 + ((n > 2) ? n - 2 : 0) + 2 * n * VF;
  endfunction

  // Expected outputs for cycle c of a run of length n (c = 0 means idle).
  function automatic logic [27:0] expect_out(int c, int n);
    int e, v, i, k;
    logic src, wer, wea, busy, done;
    logic [5:0] a1, a2, a3;
    logic [4:0] op;
    e = (n > 2) ? n - 2 : 0;
    v = 2 * n * VF;
    src = 0; wer = 0; wea = 0; busy = 0; done = 0;
    a1 = 0; a2 = 0; a3 = 0; op = 0;
    if (c != 0) begin
      busy = 1;
      if (c <= 4) begin
        a3 = 6'((c - 1) / 2);
        if (c % 2 == 0) begin src = 1; wer = 1; end
      end else if (c <= 4 + e) begin
        i = c - 3;
        a1 = 6'(i - 2); a2 = 6'(i - 1); a3 = 6'(i);
        wer = 1; wea = 1; op = 5'd1;
      end else if (c <= 4 + e + v) begin
        k = (c - 5 - e) / 2;
        a1 = 6'(k); a3 = 6'(k);
      end else begin
        done = 1;
      end
    end
    return {src, wer, wea, a1, a2, a3, op, busy, done};
  endfunction

  function automatic logic [27:0] dut_out();
    return {bus.src, bus.wer, bus.wea, bus.addr1, bus.addr2, bus.addr3,
            bus.alu_op, bus.busy, bus.done};
  endfunction

  // Compare process plus datapath read side, on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) chk("reset_outputs", dut_out(), 0);
    else        chk("cycle_outputs", dut_out(), expect_out(cyc, cur_n));
    w_en    = bus.wer;
    a_en    = bus.wea;
    w_addr  = bus.addr3;
    a_data  = regf[bus.addr1] + regf[bus.addr2];
    w_data  = bus.src ? bus.ram_dout : a_data;
    rb_data = ram[bus.addr3];
    if (bus.wea) wea_seen++;
  end

  // Datapath write side and run-cycle tracking of the reference model.
  always @(posedge clk) begin
    if (rst_n && w_en) regf[w_addr] = w_data;
    if (rst_n && a_en) ram[w_addr] = a_data;
    ram_dout_q <= rb_data;
    if (!rst_n) cyc <= 0;
    else if (cyc == 0) begin
      if (bus.start) begin cyc <= 1; cur_n <= int'(bus.len); end
    end else if (cyc == done_cycle(cur_n)) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic init_mem(input logic [31:0] s0, input logic [31:0] s1);
    for (int i = 0; i < 64; i++) begin
      regf[i] = 32'd0;
      ram[i]  = sentinel(i);
    end
    ram[0] = s0;
    ram[1] = s1;
  endtask

  task automatic check_mem(input int n, input logic [31:0] s0, input logic [31:0] s1);
    logic [31:0] m [64];
    int lim;
    m[0] = s0; m[1] = s1;
    for (int i = 2; i < 64; i++) m[i] = m[i-2] + m[i-1];
    lim = (n > 2) ? n : 2;
    for (int i = 0; i < 64; i++) begin
      if (i < lim) chk("reg_value", regf[i], m[i]);
      else         chk("reg_untouched", regf[i], 0);
      if (i >= 2 && i < lim) chk("ram_value", ram[i], m[i]);
      if (i >= lim)          chk("ram_untouched", ram[i], sentinel(i));
    end
  endtask

  task automatic run(input int n, input logic [31:0] s0, input logic [31:0] s1,
                     input int repulse_at, input int rst_at, input bit hold,
                     output int done_at, output int done_cnt, output int done2_at);
    int c, need, extra;
    init_mem(s0, s1);
    wea_seen = 0;
    done_at = -1; done2_at = -1; done_cnt = 0; extra = 0;
    need = hold ? 2 : 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 6'(n);
    c = 0;
    while (c < 400) begin
      @(negedge clk); #1;
      c++;
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) done_at = c; else done2_at = c;
      end
      if (!hold && c == 1) bus.start = 1'b0;
      if (hold && done_cnt == 1 && c == done_at + 2) bus.start = 1'b0;
      if (repulse_at > 0 && c == repulse_at) begin bus.start = 1'b1; bus.len = 6'd5; end
      if (repulse_at > 0 && c == repulse_at + 1) bus.start = 1'b0;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", dut_out(), 0);
        chk("async_reset_verify", {bus.mismatch, bus.err_addr}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      if (done_cnt >= need) begin
        extra++;
        if (extra > 6) break;
      end
    end
    if (done_cnt < need) chk("done_timeout", done_cnt, need);
  endtask

  int d, dc, d2, n;
  logic [31:0] s0, s1;
  int fibv [7] = '{2, 3, 5, 8, 13, 21, 34};

  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    init_mem(32'd0, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out", dut_out(), 0);
    chk("reset_verify", {bus.mismatch, bus.err_addr}, 0);
    #1 rst_n = 1'b1;

    // Fibonacci, len 10
    run(10, 32'd1, 32'd1, 0, 0, 1'b0, d, dc, d2);
    chk("fib_done_cycle", d, 13 + 20 * VF);
    chk("fib_done_count", dc, 1);
    chk("fib_reg9", regf[9], 55);
    chk("fib_ram9", ram[9], 55);
    for (int i = 0; i < 7; i++) chk("fib_ram_seq", ram[i+2], fibv[i]);
    chk("fib_mismatch", bus.mismatch, 0);
    check_mem(10, 32'd1, 32'd1);

    // Short runs: len 0, 1, 2
    for (int l = 0; l < 3; l++) begin
      s0 = $urandom; s1 = $urandom;
      run(l, s0, s1, 0, 0, 1'b0, d, dc, d2);
      chk("short_done_cycle", d, 5 + 2 * l * VF);
      chk("short_wea_count", wea_seen, 0);
      chk("short_reg0", regf[0], s0);
      chk("short_reg1", regf[1], s1);
      check_mem(l, s0, s1);
    end

    // start re-pulsed with len 5 during EXEC of a len 10 run
    s0 = $urandom; s1 = $urandom;
    run(10, s0, s1, 7, 0, 1'b0, d, dc, d2);
    chk("busy_done_cycle", d, 13 + 20 * VF);
    chk("busy_done_count", dc, 1);
    check_mem(10, s0, s1);

    // Reset during EXEC at i = 5, then a len 4 run
    run(10, 32'd1, 32'd1, 0, 8, 1'b0, d, dc, d2);
    run(4, 32'd3, 32'd5, 0, 0, 1'b0, d, dc, d2);
    chk("post_reset_done_cycle", d, 7 + 8 * VF);
    chk("post_reset_reg3", regf[3], 13);
    check_mem(4, 32'd3, 32'd5);

    // start held through FIN restarts in the following idle cycle
    run(3, 32'd2, 32'd7, 0, 0, 1'b1, d, dc, d2);
    chk("hold_done_cycle", d, 6 + 6 * VF);
    chk("hold_second_done", d2, 2 * (6 + 6 * VF) + 1);
    check_mem(3, 32'd2, 32'd7);

    // Random lengths and seeds (seeds wrap freely modulo 2^32)
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(3, 63));
      s0 = $urandom; s1 = $urandom;
      run(n, s0, s1, 0, 0, 1'b0, d, dc, d2);
      chk("rand_done_cycle", d, 5 + (n - 2) + 2 * n * VF);
      chk("rand_wea_count", wea_seen, n - 2);
      check_mem(n, s0, s1);
    end

    // Maximum length
    run(63, 32'd1, 32'd1, 0, 0, 1'b0, d, dc, d2);
    chk("max_done_cycle", d, 66 + 126 * VF);
    chk("max_reg62", regf[62], 32'd3350226146);
    chk("max_ram62", ram[62], 32'd3350226146);
    chk("max_ram63_untouched", ram[63], sentinel(63));
    check_mem(63, 32'd1, 32'd1);

`ifdef DATAPATH_SEQ_VERIFY_EN
    // ram_dout bumped by one in the VF_C cycle for k = 3 of a len 8 run
    bump_en = 1'b1;
    bump_cyc = 5 + 6 + 2 * 3 + 1;
    run(8, $urandom, $urandom, 0, 0, 1'b0, d, dc, d2);
    bump_en = 1'b0;
    chk("verify_done_cycle", d, 27);
    chk("verify_mismatch", bus.mismatch, 1);
    chk("verify_err_addr", bus.err_addr, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish by 500000");
    $fatal(1);
  end

endmodule
